// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared datapath widths for the operand fetch slice
// Provides DATA_W (register data), ADDR_W (register index), NREG (register
// count) and OP_W (opaque opcode width carried through the pipeline).
package cpu_pkg;

    localparam int DATA_W = 19;
    localparam int ADDR_W = 4;
    localparam int NREG   = 1 << ADDR_W;
    localparam int OP_W   = 5;

endpackage

// File: rtl/operand_scoreboard.sv
// rtl/operand_scoreboard.sv - register busy scoreboard with hazard query
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   wb_valid, wb_rd     writeback event, clears busy[wb_rd]
//   set_en, set_rd      issue of a register-writing instruction, sets busy[set_rd]
//   fclr_en, fclr_rd    discard of a held instruction, clears busy[fclr_rd]
//   rs1, rs2, rd, rd_en register indices of the instruction asking to issue
//   hazard              any referenced register still has a write outstanding
//   wb_unexpected       current writeback targets a register that is not busy
//   busy_o              raw scoreboard state
module operand_scoreboard #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int NREG   = cpu_pkg::NREG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_rd,
    input  logic              fclr_en,
    input  logic [ADDR_W-1:0] fclr_rd,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic [ADDR_W-1:0] rd,
    input  logic              rd_en,
    output logic              hazard,
    output logic              wb_unexpected,
    output logic [NREG-1:0]   busy_o
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            rd_busy;

    // A register being written back this cycle is no longer a hazard: its
    // value is forwarded by the bypass in the fetch stage.
    always_comb begin
        rs1_busy      = busy_q[rs1] && !(wb_valid && (wb_rd == rs1));
        rs2_busy      = busy_q[rs2] && !(wb_valid && (wb_rd == rs2));
        rd_busy       = busy_q[rd]  && !(wb_valid && (wb_rd == rd));
        hazard        = rs1_busy || rs2_busy || (rd_en && rd_busy);
        wb_unexpected = wb_valid && !busy_q[wb_rd];
    end

    // Clears are applied first so that a same-cycle set of the same
    // register wins.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NREG; i++) begin
            if (wb_valid && (wb_rd == ADDR_W'(i))) begin
                busy_d[i] = 1'b0;
            end
            if (fclr_en && (fclr_rd == ADDR_W'(i))) begin
                busy_d[i] = 1'b0;
            end
            if (set_en && (set_rd == ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - operand fetch stage with scoreboard, bypass and output register
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   in_valid/in_ready               issue handshake from decode
//   in_op, in_rs1, in_rs2, in_rd,
//   in_rd_en                        instruction fields
//   rf_raddr1/2, rf_rdata1/2        combinational register-file read port
//   wb_valid, wb_rd, wb_data        writeback event (mirrors the RF write port)
//   flush                           discard the held output instruction
//   out_valid/out_ready             execute-side handshake
//   out_op, out_a, out_b, out_rd,
//   out_rd_en                       issued instruction with operands
//   err_wb                          sticky: writeback to a non-busy register
module operand_fetch #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int NREG   = cpu_pkg::NREG,
    parameter int OP_W   = cpu_pkg::OP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_rd_en,
    output logic [ADDR_W-1:0] rf_raddr1,
    output logic [ADDR_W-1:0] rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_op,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [ADDR_W-1:0] out_rd,
    output logic              out_rd_en,
    output logic              err_wb
);

    logic              out_valid_q, out_valid_d;
    logic [OP_W-1:0]   out_op_q,    out_op_d;
    logic [DATA_W-1:0] out_a_q,     out_a_d;
    logic [DATA_W-1:0] out_b_q,     out_b_d;
    logic [ADDR_W-1:0] out_rd_q,    out_rd_d;
    logic              out_rd_en_q, out_rd_en_d;
    logic              err_wb_q,    err_wb_d;

    logic              hazard;
    logic              wb_unexpected;
    logic              accept;
    logic              fclr_en;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;
    logic [NREG-1:0]   busy;

    assign rf_raddr1 = in_rs1;
    assign rf_raddr2 = in_rs2;

    // Discarding a held writer releases its destination register.
    assign fclr_en = flush && out_valid_q && out_rd_en_q;

    operand_scoreboard #(
        .ADDR_W (ADDR_W),
        .NREG   (NREG)
    ) u_sb (
        .clk           (clk),
        .rst           (rst),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .set_en        (accept && in_rd_en),
        .set_rd        (in_rd),
        .fclr_en       (fclr_en),
        .fclr_rd       (out_rd_q),
        .rs1           (in_rs1),
        .rs2           (in_rs2),
        .rd            (in_rd),
        .rd_en         (in_rd_en),
        .hazard        (hazard),
        .wb_unexpected (wb_unexpected),
        .busy_o        (busy)
    );

    // The scoreboard state is only observed through hazard; the raw vector
    // is kept on the sub-module boundary for debug visibility.
    logic unused_busy;
    assign unused_busy = ^busy;

    // rst gates in_ready directly so nothing is accepted while reset is held.
    assign in_ready = !rst && (!out_valid_q || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;

    // Same-cycle bypass: the RF write lands only at the edge, so forward it.
    assign opnd_a = (wb_valid && (wb_rd == in_rs1)) ? wb_data : rf_rdata1;
    assign opnd_b = (wb_valid && (wb_rd == in_rs2)) ? wb_data : rf_rdata2;

    always_comb begin
        out_valid_d = out_valid_q;
        out_op_d    = out_op_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_rd_d    = out_rd_q;
        out_rd_en_d = out_rd_en_q;
        err_wb_d    = err_wb_q || wb_unexpected;

        // flush beats a coincident out handshake; accept is already blocked
        // by flush through in_ready.
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // Payload only moves on accept, so held operands never see later
        // writebacks.
        if (accept) begin
            out_op_d    = in_op;
            out_a_d     = opnd_a;
            out_b_d     = opnd_b;
            out_rd_d    = in_rd;
            out_rd_en_d = in_rd_en;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_op_q    <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_rd_q    <= '0;
            out_rd_en_q <= 1'b0;
            err_wb_q    <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_op_q    <= out_op_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_rd_q    <= out_rd_d;
            out_rd_en_q <= out_rd_en_d;
            err_wb_q    <= err_wb_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_op    = out_op_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_rd    = out_rd_q;
    assign out_rd_en = out_rd_en_q;
    assign err_wb    = err_wb_q;

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - directed self-checking bench for operand_fetch
module tb_operand_fetch;

    localparam int DATA_W = cpu_pkg::DATA_W;
    localparam int ADDR_W = cpu_pkg::ADDR_W;
    localparam int NREG   = cpu_pkg::NREG;
    localparam int OP_W   = cpu_pkg::OP_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_op;
    logic [ADDR_W-1:0] in_rs1, in_rs2, in_rd;
    logic              in_rd_en;
    logic [ADDR_W-1:0] rf_raddr1, rf_raddr2;
    logic [DATA_W-1:0] rf_rdata1, rf_rdata2;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [OP_W-1:0]   out_op;
    logic [DATA_W-1:0] out_a, out_b;
    logic [ADDR_W-1:0] out_rd;
    logic              out_rd_en;
    logic              err_wb;

    logic [DATA_W-1:0] rf [NREG];
    logic [NREG-1:0]   busy_view;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];
    assign busy_view = dut.u_sb.busy_o;

    operand_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_rd     (in_rd),
        .in_rd_en  (in_rd_en),
        .rf_raddr1 (rf_raddr1),
        .rf_raddr2 (rf_raddr2),
        .rf_rdata1 (rf_rdata1),
        .rf_rdata2 (rf_rdata2),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op    (out_op),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_rd    (out_rd),
        .out_rd_en (out_rd_en),
        .err_wb    (err_wb)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one clock; the RF write port commits the writeback at the edge.
    task automatic tick();
        @(posedge clk);
        if (wb_valid && !rst) rf[wb_rd] = wb_data;
        #1;
    endtask

    task automatic drive(input logic [OP_W-1:0] op, input logic [ADDR_W-1:0] rs1,
                         input logic [ADDR_W-1:0] rs2, input logic [ADDR_W-1:0] rd,
                         input logic rd_en);
        in_valid = 1'b1;
        in_op    = op;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_rd    = rd;
        in_rd_en = rd_en;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_rs1 = '0; in_rs2 = '0;
        in_rd = '0; in_rd_en = 1'b0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        flush = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < NREG; i++) rf[i] = '0;
        rf[1] = 19'h00101; rf[2] = 19'h00011; rf[3] = 19'h00022;
        rf[6] = 19'h00066; rf[7] = 19'h00077;

        // Reset state
        tick(); tick();
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_err_wb",    32'(err_wb),    32'h0);
        check("rst_out_a",     32'(out_a),     32'h0);
        check("rst_out_op",    32'(out_op),    32'h0);
        check("rst_out_rd_en", 32'(out_rd_en), 32'h0);
        check("rst_busy",      32'(busy_view), 32'h0);
        check("rst_in_ready",  32'(in_ready),  32'h0);
        rst = 1'b0;

        // Basic issue
        drive(5'h0A, 4'd2, 4'd3, 4'd4, 1'b1);
        #1 check("issue_in_ready", 32'(in_ready), 32'h1);
        tick();
        check("issue_out_valid", 32'(out_valid), 32'h1);
        check("issue_out_a",     32'(out_a),     32'h00011);
        check("issue_out_b",     32'(out_b),     32'h00022);
        check("issue_out_rd",    32'(out_rd),    32'h4);
        check("issue_out_op",    32'(out_op),    32'h0A);
        check("issue_busy",      32'(busy_view), 32'h0010);

        // RAW hazard resolved by same-cycle writeback bypass
        out_ready = 1'b1;
        drive(5'h01, 4'd4, 4'd0, 4'd0, 1'b0);
        #1 check("hazard_in_ready", 32'(in_ready), 32'h0);
        wb_valid = 1'b1; wb_rd = 4'd4; wb_data = 19'h7FFFF;
        #1 check("bypass_in_ready", 32'(in_ready), 32'h1);
        tick();
        wb_valid = 1'b0;
        check("bypass_out_valid", 32'(out_valid), 32'h1);
        check("bypass_out_a",     32'(out_a),     32'h7FFFF);
        check("bypass_out_op",    32'(out_op),    32'h01);
        check("bypass_busy",      32'(busy_view), 32'h0);

        // Back-pressure hold, then back-to-back issue
        drive(5'h03, 4'd1, 4'd2, 4'd5, 1'b1);
        #1 check("hold_pre_in_ready", 32'(in_ready), 32'h1);
        tick();
        check("hold_pre_out_a", 32'(out_a), 32'h00101);
        check("hold_pre_out_b", 32'(out_b), 32'h00011);
        check("hold_pre_busy",  32'(busy_view), 32'h0020);
        out_ready = 1'b0;
        drive(5'h04, 4'd6, 4'd7, 4'd8, 1'b1);
        for (int k = 0; k < 5; k++) begin
            #1 check("hold_in_ready", 32'(in_ready), 32'h0);
            tick();
            check("hold_out_valid", 32'(out_valid), 32'h1);
            check("hold_out_a",     32'(out_a),     32'h00101);
            check("hold_out_rd",    32'(out_rd),    32'h5);
        end
        out_ready = 1'b1;
        #1 check("b2b_in_ready", 32'(in_ready), 32'h1);
        tick();
        check("b2b_out_valid", 32'(out_valid), 32'h1);
        check("b2b_out_a",     32'(out_a),     32'h00066);
        check("b2b_out_b",     32'(out_b),     32'h00077);
        check("b2b_out_rd",    32'(out_rd),    32'h8);
        check("b2b_busy",      32'(busy_view), 32'h0120);

        // Flush of held writer (coincides with out_ready: flush wins)
        in_valid = 1'b0;
        tick();
        check("drain_out_valid", 32'(out_valid), 32'h0);
        out_ready = 1'b0;
        drive(5'h05, 4'd0, 4'd0, 4'd7, 1'b1);
        tick();
        check("r7_out_valid", 32'(out_valid), 32'h1);
        check("r7_busy",      32'(busy_view), 32'h01A0);
        flush = 1'b1; out_ready = 1'b1;
        drive(5'h06, 4'd7, 4'd0, 4'd0, 1'b0);
        #1 check("flush_in_ready", 32'(in_ready), 32'h0);
        tick();
        flush = 1'b0;
        check("flush_out_valid", 32'(out_valid), 32'h0);
        check("flush_busy",      32'(busy_view), 32'h0120);
        #1 check("post_flush_in_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        check("post_flush_out_valid", 32'(out_valid), 32'h1);
        check("post_flush_out_a",     32'(out_a),     32'h00077);
        check("post_flush_out_op",    32'(out_op),    32'h06);

        // Spurious writeback sets the sticky error
        wb_valid = 1'b1; wb_rd = 4'd9; wb_data = 19'h12345;
        tick();
        wb_valid = 1'b0;
        check("errwb_set",  32'(err_wb),    32'h1);
        check("errwb_busy", 32'(busy_view), 32'h0120);
        tick(); tick(); tick();
        check("errwb_sticky", 32'(err_wb), 32'h1);
        wb_valid = 1'b1; wb_rd = 4'd5; wb_data = 19'h00055;
        tick();
        wb_valid = 1'b0;
        check("wb5_busy",   32'(busy_view), 32'h0100);
        check("wb5_err_wb", 32'(err_wb),    32'h1);

        // Asynchronous reset mid-operation
        out_ready = 1'b0;
        drive(5'h07, 4'd0, 4'd0, 4'd5, 1'b1);
        tick();
        check("pre_arst_out_valid", 32'(out_valid), 32'h1);
        check("pre_arst_busy",      32'(busy_view), 32'h0120);
        drive(5'h08, 4'd0, 4'd0, 4'd0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'h0);
        check("arst_busy",      32'(busy_view), 32'h0);
        check("arst_err_wb",    32'(err_wb),    32'h0);
        check("arst_out_a",     32'(out_a),     32'h0);
        check("arst_out_rd",    32'(out_rd),    32'h0);
        check("arst_in_ready",  32'(in_ready),  32'h0);
        tick();
        check("arst_hold_out_valid", 32'(out_valid), 32'h0);
        rst = 1'b0;
        in_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
